// File: rtl/alu_buf_pkg.sv
// Shared types and constants for the ALU result buffer.
package alu_buf_pkg;

    localparam int ALU_DATA_W   = 32;
    localparam int ERR_DROP     = 0;
    localparam int ERR_SPURIOUS = 1;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
    } alu_flags_t;

    localparam int FLAGS_W = $bits(alu_flags_t);

    typedef struct packed {
        alu_flags_t            flags;
        logic [ALU_DATA_W-1:0] result;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Circular result store: write/read pointers, occupancy count and the
// entry array. The caller guarantees push is never asserted when full
// without a simultaneous pop, and pop is never asserted when empty.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Entry storage: no reset, contents are only meaningful below occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read straight from the array so a result is visible the
    // cycle after it is written.
    assign rd_data   = mem[rd_ptr_reg];
    assign occupancy = count_reg;

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers fixed-latency ALU results for a valid/ready consumer and hands
// out issue credits so buffered + in-flight results never exceed DEPTH.
module alu_result_buffer
    import alu_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       issue_ready,
    input  logic                       issue_fire,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [2:0]                 in_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic [1:0]                 err
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = FLAGS_W + DATA_W;

    logic                push;
    logic                pop;
    logic                full;
    logic [ENTRY_W-1:0]  wr_data;
    logic [ENTRY_W-1:0]  rd_data;
    logic [CNT_W-1:0]    fifo_occupancy;
    logic [CNT_W-1:0]    inflight_reg;
    logic [1:0]          err_reg;
    logic [CNT_W:0]      credit_sum;
    alu_flags_t          head_flags;

    assign full      = (fifo_occupancy == CNT_W'(DEPTH));
    assign out_valid = (fifo_occupancy != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push      = in_valid && (!full || pop);
    assign wr_data   = {in_flags, in_result};

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .occupancy (fifo_occupancy)
    );

    // Credits come only from registered state; a pop frees a credit next cycle.
    assign credit_sum  = {1'b0, fifo_occupancy} + {1'b0, inflight_reg};
    assign issue_ready = reset && (credit_sum < (CNT_W+1)'(DEPTH));

    // Outputs read as zero whenever nothing is buffered, including in reset.
    assign head_flags = alu_flags_t'(rd_data[DATA_W +: FLAGS_W]);
    assign out_result = out_valid ? rd_data[DATA_W-1:0] : '0;
    assign out_flags  = out_valid ? head_flags : '0;
    assign occupancy  = fifo_occupancy;
    assign inflight   = inflight_reg;
    assign err        = err_reg;

    // In-flight tracking: issue adds, return subtracts, saturating at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_reg <= '0;
        end else begin
            case ({issue_fire, in_valid})
                2'b10: inflight_reg <= inflight_reg + CNT_W'(1);
                2'b01: begin
                    if (inflight_reg != '0) begin
                        inflight_reg <= inflight_reg - CNT_W'(1);
                    end
                end
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    // Sticky protocol error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_reg <= '0;
        end else begin
            if (in_valid && !push) begin
                err_reg[ERR_DROP] <= 1'b1;
            end
            if (in_valid && !issue_fire && (inflight_reg == '0)) begin
                err_reg[ERR_SPURIOUS] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a queue-based reference model
// checked every cycle plus hand-computed literal checks.
module tb_alu_result_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              issue_ready;
    logic              issue_fire;
    logic              in_valid;
    logic [DATA_W-1:0] in_result;
    logic [2:0]        in_flags;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [2:0]        out_flags;
    logic [2:0]        occupancy;
    logic [2:0]        inflight;
    logic [1:0]        err;

    int compared   = 0;
    int mismatched = 0;

    alu_result_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_ready (issue_ready),
        .issue_fire  (issue_fire),
        .in_valid    (in_valid),
        .in_result   (in_result),
        .in_flags    (in_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .occupancy   (occupancy),
        .inflight    (inflight),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [34:0] m_q[$];
    int          m_inflight = 0;
    logic [1:0]  m_err      = 2'b00;
    bit          m_pop;
    bit          m_full;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_inflight = 0;
            m_err      = 2'b00;
        end else begin
            m_pop  = (m_q.size() != 0) && (out_ready === 1'b1);
            m_full = (m_q.size() == DEPTH);
            if (m_pop) void'(m_q.pop_front());
            if (in_valid) begin
                if (!m_full || m_pop) m_q.push_back({in_flags, in_result});
                else                  m_err[0] = 1'b1;
            end
            if (issue_fire && !in_valid) begin
                m_inflight++;
            end else if (in_valid && !issue_fire) begin
                if (m_inflight == 0) m_err[1] = 1'b1;
                else                 m_inflight--;
            end
        end
    end

    bit compare_en = 1'b0;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (compare_en) begin
            chk("issue_ready", issue_ready, reset && ((m_q.size() + m_inflight) < DEPTH));
            chk("out_valid", out_valid, m_q.size() != 0);
            chk("occupancy", occupancy, m_q.size());
            chk("inflight", inflight, m_inflight);
            chk("err", err, m_err);
            if (m_q.size() != 0) begin
                chk("out_result", out_result, m_q[0][31:0]);
                chk("out_flags", out_flags, m_q[0][34:32]);
            end
        end
    end

    // Record consumer handshakes for the wrap-around order check.
    logic [34:0] got_q[$];
    always @(posedge clk) begin
        if (reset && out_valid && out_ready) got_q.push_back({out_flags, out_result});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          issued;
    int          returned;
    int          cyc;
    int          due_q[$];
    logic [34:0] want;

    initial begin
        reset      = 1'b1;
        issue_fire = 1'b0;
        in_valid   = 1'b0;
        in_result  = '0;
        in_flags   = '0;
        out_ready  = 1'b0;
        #1 reset   = 1'b0;
        compare_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;

        // Reset then idle
        chk("idle_issue_ready", issue_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_occupancy", occupancy, 0);
        chk("idle_inflight", inflight, 0);
        chk("idle_err", err, 0);
        step();

        // Single op: issue in cycle 0, result in cycle 4, visible in cycle 5
        issue_fire = 1'b1;
        step();
        issue_fire = 1'b0;
        chk("single_inflight_c1", inflight, 1);
        step(); step(); step();
        chk("single_inflight_c4", inflight, 1);
        in_valid  = 1'b1;
        in_result = 32'h4040_0000;
        in_flags  = 3'b000;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_out_valid_c5", out_valid, 1);
        chk("single_out_result_c5", out_result, 32'h4040_0000);
        chk("single_inflight_c5", inflight, 0);
        step();
        chk("single_occupancy_after_pop", occupancy, 0);

        // Credit exhaustion
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_fire = 1'b1;
            step();
        end
        issue_fire = 1'b0;
        chk("credit_issue_ready_exhausted", issue_ready, 0);
        chk("credit_inflight_4", inflight, 4);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_result = 32'h1000_0001 + 32'(i);
            in_flags  = 3'(i);
            step();
        end
        in_valid = 1'b0;
        chk("credit_occupancy_4", occupancy, 4);
        chk("credit_issue_ready_full", issue_ready, 0);
        chk("credit_head0", out_result, 32'h1000_0001);
        out_ready = 1'b1;
        step();
        chk("credit_issue_ready_after_pop", issue_ready, 1);
        chk("credit_head1", out_result, 32'h1000_0002);
        chk("credit_head1_flags", out_flags, 3'b001);
        step(); step(); step();
        out_ready = 1'b0;
        chk("credit_drained", occupancy, 0);

        // Wrap-around: 10 ops with 4-cycle ALU latency and random back-pressure
        got_q.delete();
        issued   = 0;
        returned = 0;
        cyc      = 0;
        while ((got_q.size() < 10) && (cyc < 300)) begin
            issue_fire = issue_ready && (issued < 10);
            if (issue_fire) begin
                due_q.push_back(cyc + 4);
                issued++;
            end
            if ((due_q.size() != 0) && (due_q[0] == cyc)) begin
                in_valid  = 1'b1;
                in_result = 32'hA000_0000 + 32'(returned);
                in_flags  = (returned % 3 == 2) ? 3'b100 : 3'b000;
                returned++;
                void'(due_q.pop_front());
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        issue_fire = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        chk("wrap_count", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            want = {((i % 3 == 2) ? 3'b100 : 3'b000), 32'hA000_0000 + 32'(i)};
            chk($sformatf("wrap_entry%0d", i), got_q[i], want);
        end
        chk("wrap_err", err, 0);
        chk("wrap_inflight", inflight, 0);

        // Protocol violations: spurious results, then a drop while full
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_result = 32'hBAD0_0000 + 32'(i);
            in_flags  = 3'b010;
            step();
            if (i == 0) chk("viol_spurious_err", err, 2'b10);
        end
        in_valid = 1'b0;
        chk("viol_drop_err", err, 2'b11);
        chk("viol_occupancy_4", occupancy, 4);
        chk("viol_head", out_result, 32'hBAD0_0000);
        step(); step(); step();
        chk("viol_err_sticky_idle", err, 2'b11);
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        chk("viol_drained", occupancy, 0);
        chk("viol_err_sticky_drain", err, 2'b11);

        // Async reset mid-stream with occupancy=3, inflight=1
        for (int i = 0; i < 4; i++) begin
            issue_fire = 1'b1;
            step();
        end
        issue_fire = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_result = 32'hC000_0000 + 32'(i);
            in_flags  = 3'b001;
            step();
        end
        in_valid = 1'b0;
        chk("rst_pre_occupancy", occupancy, 3);
        chk("rst_pre_inflight", inflight, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_occupancy", occupancy, 0);
        chk("rst_async_inflight", inflight, 0);
        chk("rst_async_err", err, 0);
        chk("rst_async_issue_ready", issue_ready, 0);
        chk("rst_async_out_result", out_result, 0);
        chk("rst_async_out_flags", out_flags, 0);
        step();
        reset = 1'b1;
        step();
        chk("rst_release_issue_ready", issue_ready, 1);
        chk("rst_release_out_valid", out_valid, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
